// File: rtl/knob_step_decoder.sv
// Quadrature encoder decoder: sync, debounce, phase tracking and per-detent move strobes.
// One instance per PmodENC encoder; feeds the cursor move strobes of dot_trace_gen.
`timescale 1ns/1ps

module knob_step_decoder #(
    parameter int DB_CYCLES      = 100000,
    parameter int STEPS_PER_MOVE = 4
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       enc_a,
    input  logic       enc_b,
    input  logic       hold,
    output logic       move_inc,
    output logic       move_dec,
    output logic       err_pulse,
    output logic [1:0] dir_led
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
    localparam logic signed [4:0] ACC_MAX = 5'(STEPS_PER_MOVE - 1);
    localparam logic signed [4:0] ACC_MIN = -ACC_MAX;

    typedef enum logic {INIT, TRACK} state_t;

    logic [1:0]        sync1;
    logic [1:0]        sync2;
    logic [1:0]        stab;
    logic [CW-1:0]     db_cnt [2];
    logic [CW-1:0]     init_cnt;
    state_t            state;
    logic [1:0]        prev_q;
    logic [1:0]        q;
    logic [1:0]        diff;
    logic              step_fwd;
    logic              step_rev;
    logic              step_err;
    logic signed [4:0] acc;

    // Gray phase 00,10,11,01 mapped to 0..3 so direction is a modulo-4 difference.
    function automatic logic [1:0] phase_idx(input logic [1:0] p);
        return {p[0], p[1] ^ p[0]};
    endfunction

    assign q    = stab;
    assign diff = phase_idx(q) - phase_idx(prev_q);

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            stab      <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync1 <= {enc_a, enc_b};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == stab[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stab[i]   <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end
            end
        end
    end

    // INIT waits for both channels to sit quietly so a resting encoder never steps.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state    <= INIT;
            init_cnt <= '0;
            prev_q   <= '0;
            step_fwd <= 1'b0;
            step_rev <= 1'b0;
            step_err <= 1'b0;
        end else begin
            step_fwd <= 1'b0;
            step_rev <= 1'b0;
            step_err <= 1'b0;
            unique case (state)
                INIT: begin
                    if (sync2 != stab) begin
                        init_cnt <= '0;
                    end else if (init_cnt == DB_LAST) begin
                        init_cnt <= '0;
                        prev_q   <= q;
                        state    <= TRACK;
                    end else begin
                        init_cnt <= init_cnt + CW'(1);
                    end
                end
                TRACK: begin
                    prev_q <= q;
                    if (!hold) begin
                        step_fwd <= (diff == 2'd1);
                        step_rev <= (diff == 2'd3);
                        step_err <= (diff == 2'd2);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            move_inc  <= 1'b0;
            move_dec  <= 1'b0;
            err_pulse <= 1'b0;
            dir_led   <= 2'b00;
        end else begin
            move_inc  <= 1'b0;
            move_dec  <= 1'b0;
            err_pulse <= 1'b0;
            if (hold) begin
                acc <= '0;
            end else if (step_err) begin
                acc       <= '0;
                err_pulse <= 1'b1;
            end else if (step_fwd) begin
                if (acc == ACC_MAX) begin
                    acc      <= '0;
                    move_inc <= 1'b1;
                    dir_led  <= 2'b10;
                end else begin
                    acc <= acc + 5'sd1;
                end
            end else if (step_rev) begin
                if (acc == ACC_MIN) begin
                    acc      <= '0;
                    move_dec <= 1'b1;
                    dir_led  <= 2'b01;
                end else begin
                    acc <= acc - 5'sd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_knob_step_decoder.sv
// Scoreboard bench for knob_step_decoder: a detent model predicts each strobe,
// its clock and dir_led; a negedge monitor pops and compares every DUT strobe.
`timescale 1ns/1ps

module tb_knob_step_decoder;

    localparam int DB    = 4;
    localparam int STEPS = 4;
    localparam int LAT   = DB + 4;

    logic       clk_100MHz = 1'b0;
    logic       reset      = 1'b1;
    logic       enc_a      = 1'b1;
    logic       enc_b      = 1'b1;
    logic       hold       = 1'b0;
    logic       move_inc;
    logic       move_dec;
    logic       err_pulse;
    logic [1:0] dir_led;

    knob_step_decoder #(
        .DB_CYCLES      (DB),
        .STEPS_PER_MOVE (STEPS)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .enc_a      (enc_a),
        .enc_b      (enc_b),
        .hold       (hold),
        .move_inc   (move_inc),
        .move_dec   (move_dec),
        .err_pulse  (err_pulse),
        .dir_led    (dir_led)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int cyc = 0;
    always @(posedge clk_100MHz) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         cyc;
        logic [2:0] kind;
        logic [1:0] dir;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        mon_ev;
    logic [1:0] m_prev;
    int         m_acc;
    logic [1:0] m_dir;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_100MHz);
            #1;
        end
    endtask

    task automatic push_ev(input logic [2:0] kind);
        ev_t e;
        e.cyc  = cyc + LAT;
        e.kind = kind;
        e.dir  = m_dir;
        exp_q.push_back(e);
    endtask

    task automatic model_step(input logic [1:0] v);
        logic [3:0] t;
        t = {m_prev, v};
        if (v == m_prev) return;
        if (hold) begin
            m_acc = 0;
        end else if (t inside {4'b0010, 4'b1011, 4'b1101, 4'b0100}) begin
            m_acc++;
            if (m_acc == STEPS) begin
                m_acc = 0;
                m_dir = 2'b10;
                push_ev(3'b100);
            end
        end else if (t inside {4'b0001, 4'b0111, 4'b1110, 4'b1000}) begin
            m_acc--;
            if (m_acc == -STEPS) begin
                m_acc = 0;
                m_dir = 2'b01;
                push_ev(3'b010);
            end
        end else begin
            m_acc = 0;
            push_ev(3'b001);
        end
        m_prev = v;
    endtask

    task automatic drive(input logic [1:0] v, input int n);
        model_step(v);
        {enc_a, enc_b} = v;
        tick(n);
    endtask

    always @(negedge clk_100MHz) begin
        if (!reset && (move_inc || move_dec || err_pulse)) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious", 32'({move_inc, move_dec, err_pulse}), 0);
            end else begin
                mon_ev = exp_q.pop_front();
                check_eq("ev_kind", 32'({move_inc, move_dec, err_pulse}),
                         32'(mon_ev.kind));
                check_eq("ev_cyc", cyc, mon_ev.cyc);
                check_eq("ev_dir", 32'(dir_led), 32'(mon_ev.dir));
            end
        end
    end

    initial begin
        reset = 1'b1;
        {enc_a, enc_b} = 2'b11;
        tick(3);
        check_eq("rst_inc", 32'(move_inc), 0);
        check_eq("rst_dec", 32'(move_dec), 0);
        check_eq("rst_err", 32'(err_pulse), 0);
        check_eq("rst_dir", 32'(dir_led), 0);

        reset  = 1'b0;
        m_prev = 2'b11;
        m_acc  = 0;
        m_dir  = 2'b00;
        tick(20);
        check_eq("t1_dir", 32'(dir_led), 0);

        hold = 1'b1;
        drive(2'b01, 10);
        drive(2'b00, 10);
        hold = 1'b0;

        drive(2'b10, 10);
        drive(2'b11, 10);
        drive(2'b01, 10);
        drive(2'b00, 10);
        check_eq("t2_dir", 32'(dir_led), 2);

        drive(2'b01, 10);
        drive(2'b11, 10);
        drive(2'b10, 10);
        drive(2'b00, 10);
        check_eq("t3_dir", 32'(dir_led), 1);
        drive(2'b10, 10);
        drive(2'b11, 10);
        drive(2'b10, 10);
        drive(2'b00, 10);

        for (int i = 0; i < 20; i++) begin
            enc_a = ~enc_a;
            tick(2);
        end
        tick(10);

        drive(2'b11, 10);
        drive(2'b01, 10);
        drive(2'b00, 10);
        drive(2'b10, 10);
        drive(2'b11, 10);

        hold = 1'b1;
        drive(2'b01, 10);
        drive(2'b00, 10);
        drive(2'b10, 10);
        drive(2'b11, 10);
        hold = 1'b0;
        drive(2'b01, 10);
        drive(2'b00, 10);
        drive(2'b10, 10);
        drive(2'b11, 10);
        check_eq("t6_dir", 32'(dir_led), 2);

        drive(2'b01, 10);
        drive(2'b00, 10);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_inc", 32'(move_inc), 0);
        check_eq("mid_rst_dec", 32'(move_dec), 0);
        check_eq("mid_rst_err", 32'(err_pulse), 0);
        check_eq("mid_rst_dir", 32'(dir_led), 0);
        tick(3);
        reset  = 1'b0;
        m_prev = 2'b00;
        m_acc  = 0;
        m_dir  = 2'b00;
        tick(20);
        drive(2'b10, 10);
        drive(2'b11, 10);
        tick(20);
        check_eq("post_rst_dir", 32'(dir_led), 0);
        check_eq("drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
